// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared constants for the seven-segment scanner
package sev_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_SEGS   = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_BLANK = 2'd0;
  localparam phase_t PH_ON    = 2'd1;
  localparam phase_t PH_OFF   = 2'd2;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/sev_seg_slot_timer.sv
// rtl/sev_seg_slot_timer.sv - slot counter, PWM step index and digit index
// Phase is combinational from the counters; the top registers the pins from it.
module sev_seg_slot_timer
  import sev_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 12512,
  parameter int BLANK_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] brightness,
  output logic [1:0] phase,
  output logic [1:0] digit_idx,
  output logic       frame_start
);

  localparam int STEP   = (DIGIT_PERIOD - BLANK_CYCLES) / 16;
  localparam int CNT_W  = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIGIT_PERIOD - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP - 1);

  logic [CNT_W-1:0]  cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [3:0]        step_idx;
  logic              in_blank;

  assign in_blank = (cnt <= BLANK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      step_cnt  <= '0;
      step_idx  <= '0;
      digit_idx <= '0;
    end else if (!en) begin
      cnt       <= '0;
      step_cnt  <= '0;
      step_idx  <= '0;
      digit_idx <= '0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Step counters restart exactly where the lit window begins.
      if (cnt == BLANK_LAST) begin
        step_cnt <= '0;
        step_idx <= '0;
      end else if (!in_blank) begin
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          step_idx <= step_idx + 4'd1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    phase = PH_BLANK;
    if (!en || in_blank) begin
      phase = PH_BLANK;
    end else if (step_idx <= brightness) begin
      phase = PH_ON;
    end else begin
      phase = PH_OFF;
    end
  end

  assign frame_start = en && (cnt == '0) && (digit_idx == 2'd0);

endmodule

// File: rtl/sev_seg_scanner.sv
// rtl/sev_seg_scanner.sv - 4-digit multiplexed seven-segment pin driver
// Inputs are snapshotted once per frame so bus writes never tear a frame.
module sev_seg_scanner
  import sev_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD   = 12512,
  parameter int BLANK_CYCLES   = 32,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic [6:0] ctrl_digit_0,
  input  logic [6:0] ctrl_digit_1,
  input  logic [6:0] ctrl_digit_2,
  input  logic [6:0] ctrl_digit_3,
  input  logic [3:0] ctrl_dots,
  input  logic [3:0] brightness,
  output logic [3:0] sel_out,
  output logic [6:0] seg_out,
  output logic       dp_out
);

  localparam logic [NUM_DIGITS-1:0] SEL_MASK = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [NUM_SEGS-1:0]   SEG_MASK = {NUM_SEGS{SEG_ACTIVE_LOW}};
  localparam logic                  DP_MASK  = SEG_ACTIVE_LOW;

  logic                  en_q;
  logic [NUM_SEGS-1:0]   snap_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dot;
  logic [3:0]            snap_bright;

  logic [1:0] phase;
  logic [1:0] digit_idx;
  logic       frame_start;

  sev_seg_slot_timer #(
    .DIGIT_PERIOD (DIGIT_PERIOD),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (en_q),
    .brightness  (snap_bright),
    .phase       (phase),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= ctrl_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap_seg[i] <= '0;
      end
      snap_dot    <= '0;
      snap_bright <= '0;
    end else if (frame_start) begin
      snap_seg[0] <= ctrl_digit_0;
      snap_seg[1] <= ctrl_digit_1;
      snap_seg[2] <= ctrl_digit_2;
      snap_seg[3] <= ctrl_digit_3;
      snap_dot    <= ctrl_dots;
      snap_bright <= brightness;
    end
  end

  // BLANK and OFF both park every pin at its inactive level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_out <= SEL_MASK;
      seg_out <= SEG_MASK;
      dp_out  <= DP_MASK;
    end else if (phase == PH_ON) begin
      sel_out <= digit_onehot(digit_idx) ^ SEL_MASK;
      seg_out <= snap_seg[digit_idx] ^ SEG_MASK;
      dp_out  <= snap_dot[digit_idx] ^ DP_MASK;
    end else begin
      sel_out <= SEL_MASK;
      seg_out <= SEG_MASK;
      dp_out  <= DP_MASK;
    end
  end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// tb/tb_sev_seg_scanner.sv - directed bench for sev_seg_scanner
module tb_sev_seg_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_en;
  logic [6:0] ctrl_digit_0, ctrl_digit_1, ctrl_digit_2, ctrl_digit_3;
  logic [3:0] ctrl_dots;
  logic [3:0] brightness;
  logic [3:0] sel_out;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [11:0] pins;

  int tests = 0;
  int fails = 0;
  int sel_viol = 0;

  localparam logic [11:0] IDLE = {4'hF, 7'h7F, 1'b1};
  logic [11:0] lit_exp [4];

  always #5 clk = ~clk;

  assign pins = {sel_out, seg_out, dp_out};

  sev_seg_scanner #(
    .DIGIT_PERIOD   (40),
    .BLANK_CYCLES   (8),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_en      (ctrl_en),
    .ctrl_digit_0 (ctrl_digit_0),
    .ctrl_digit_1 (ctrl_digit_1),
    .ctrl_digit_2 (ctrl_digit_2),
    .ctrl_digit_3 (ctrl_digit_3),
    .ctrl_dots    (ctrl_dots),
    .brightness   (brightness),
    .sel_out      (sel_out),
    .seg_out      (seg_out),
    .dp_out       (dp_out)
  );

  always @(negedge clk) begin
    if ($countones(~sel_out) > 1) sel_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts consecutive samples equal to the current pin value; returns on the first different one.
  task automatic run_len(output logic [11:0] val, output int len);
    val = pins;
    len = 0;
    while (pins === val && len < 500) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic expect_run(input string tag, input logic [11:0] exp_val, input int exp_len);
    logic [11:0] v;
    int n;
    run_len(v, n);
    check({tag, "_val"}, v, exp_val);
    check({tag, "_len"}, n, exp_len);
  endtask

  task automatic scan_frame(input string tag, input int lit_len, input int dark_len);
    for (int d = 0; d < 4; d++) begin
      expect_run($sformatf("%s_d%0d_lit", tag, d), lit_exp[d], lit_len);
      expect_run($sformatf("%s_d%0d_dark", tag, d), IDLE, dark_len);
    end
  endtask

  task automatic start(input logic [3:0] b);
    ctrl_en = 1'b0;
    repeat (3) @(negedge clk);
    brightness = b;
    ctrl_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    lit_exp[0] = {4'hE, 7'h40, 1'b0};
    lit_exp[1] = {4'hD, 7'h79, 1'b1};
    lit_exp[2] = {4'hB, 7'h24, 1'b0};
    lit_exp[3] = {4'h7, 7'h30, 1'b1};

    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ctrl_en      = 1'($urandom);
      ctrl_digit_0 = 7'($urandom);
      ctrl_digit_1 = 7'($urandom);
      ctrl_digit_2 = 7'($urandom);
      ctrl_digit_3 = 7'($urandom);
      ctrl_dots    = 4'($urandom);
      brightness   = 4'($urandom);
      @(negedge clk);
      check($sformatf("rst_pins_%0d", i), pins, IDLE);
    end
    ctrl_en      = 1'b0;
    ctrl_digit_0 = 7'h3F;
    ctrl_digit_1 = 7'h06;
    ctrl_digit_2 = 7'h5B;
    ctrl_digit_3 = 7'h4F;
    ctrl_dots    = 4'b0101;
    brightness   = 4'hF;
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pins !== IDLE) bad++;
    end
    check("idle_after_rst", bad, 0);

    // Basic scan, full brightness, two frames
    start(4'hF);
    expect_run("s2_blank0", IDLE, 9);
    scan_frame("s2f1", 32, 8);
    scan_frame("s2f2", 32, 8);

    // Brightness levels
    start(4'h3);
    expect_run("b3_blank0", IDLE, 9);
    scan_frame("b3", 8, 32);
    start(4'h0);
    expect_run("b0_blank0", IDLE, 9);
    scan_frame("b0", 2, 38);

    // No tearing: digit 2 changes while digit 1 is lit
    start(4'hF);
    expect_run("nt_blank0", IDLE, 9);
    expect_run("nt_f1_d0", lit_exp[0], 32);
    expect_run("nt_f1_b0", IDLE, 8);
    ctrl_digit_2 = 7'h7F;
    expect_run("nt_f1_d1", lit_exp[1], 32);
    expect_run("nt_f1_b1", IDLE, 8);
    expect_run("nt_f1_d2", lit_exp[2], 32);
    expect_run("nt_f1_b2", IDLE, 8);
    expect_run("nt_f1_d3", lit_exp[3], 32);
    expect_run("nt_f1_b3", IDLE, 8);
    expect_run("nt_f2_d0", lit_exp[0], 32);
    expect_run("nt_f2_b0", IDLE, 8);
    expect_run("nt_f2_d1", lit_exp[1], 32);
    expect_run("nt_f2_b1", IDLE, 8);
    expect_run("nt_f2_d2", {4'hB, 7'h00, 1'b0}, 32);
    ctrl_digit_2 = 7'h5B;

    // Disable during digit 2 ON, then re-enable
    start(4'hF);
    expect_run("de_blank0", IDLE, 9);
    expect_run("de_d0", lit_exp[0], 32);
    expect_run("de_b0", IDLE, 8);
    expect_run("de_d1", lit_exp[1], 32);
    expect_run("de_b1", IDLE, 8);
    repeat (3) @(negedge clk);
    check("de_d2_on", pins, lit_exp[2]);
    ctrl_en = 1'b0;
    @(negedge clk);
    check("de_lat1", pins, lit_exp[2]);
    @(negedge clk);
    check("de_lat2", pins, IDLE);
    repeat (5) @(negedge clk);
    check("de_hold", pins, IDLE);
    ctrl_en = 1'b1;
    @(negedge clk);
    expect_run("re_blank", IDLE, 9);
    expect_run("re_d0", lit_exp[0], 32);

    // Async reset in the middle of an ON phase
    start(4'hF);
    expect_run("ar_blank0", IDLE, 9);
    repeat (4) @(negedge clk);
    check("ar_pre", pins, lit_exp[0]);
    #1 rst = 1'b0;
    #1 check("ar_async", pins, IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_run("ar_blank", IDLE, 9);
    expect_run("ar_d0", lit_exp[0], 32);
    expect_run("ar_b0", IDLE, 8);
    expect_run("ar_d1", lit_exp[1], 32);

    check("one_sel_max", sel_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sev_seg_scanner.md
Name: sev_seg_scanner

Overview:
- Time-multiplexing driver that sits directly downstream of the seven-segment bus interface.
- Consumes its decoded per-digit segment patterns, dot bits and enable, and drives the physical 4-digit common-select display pins.
- Scans one digit at a time, with an anti-ghosting blank interval and PWM brightness.
- Samples its inputs once per frame so that CPU writes never tear a frame.

Parameters:
DIGIT_PERIOD, 12512, clock cycles per digit slot; (DIGIT_PERIOD - BLANK_CYCLES) must be a nonzero multiple of 16
BLANK_CYCLES, 32, cycles at slot start with all digit selects inactive; must be >= 1
SEG_ACTIVE_LOW, 1, 1: seg_out/dp_out pins are low-true; 0: high-true
SEL_ACTIVE_LOW, 1, 1: sel_out pins are low-true; 0: high-true

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
ctrl_en  in  1  display enable from bus interface
ctrl_digit_0..ctrl_digit_3  in  7 each  segment pattern per digit, bit0=a .. bit6=g, 1=lit
ctrl_dots  in  4  dot per digit, bit i = digit i, 1=lit
brightness  in  4  PWM level 0..15 (tie 4'hF when unused)
sel_out  out  4  digit select pins, bit i = digit i
seg_out  out  7  segment pins a..g
dp_out  out  1  decimal point pin

Behaviour:
- Terminology: "active"/"inactive" means pin levels after applying the polarity parameters. STEP = (DIGIT_PERIOD - BLANK_CYCLES)/16.
- Reset (rst=0, async):
  - cnt=0, digit_idx=0, en_q=0, snapshot registers (4x7 segments, 4 dots, brightness) = 0.
  - All outputs inactive: sel_out all inactive, seg_out all inactive, dp_out inactive.
- en_q: registers ctrl_en every cycle.
- While en_q=0:
  - cnt and digit_idx are held at 0.
  - Outputs are driven inactive.
- en_q 0->1: scanning starts at cnt=0, digit_idx=0, and a snapshot is taken on that cycle.
- Slot counter cnt (0..DIGIT_PERIOD-1):
  - cnt=DIGIT_PERIOD-1 -> cnt wraps to 0 and digit_idx increments, wrapping 3->0.
- Snapshot: loaded from ctrl_digit_*, ctrl_dots and brightness when cnt=0 && digit_idx=0 && en_q=1. Held for the rest of the frame.
- Slot phases (a registered decision, see latency below):
  - BLANK: cnt < BLANK_CYCLES. No select is active; seg/dp are also driven inactive.
  - ON: step = (cnt - BLANK_CYCLES)/STEP, in 0..15, and step <= snapshot brightness. Only sel_out[digit_idx] is active; seg_out = snap_seg[digit_idx]; dp_out = snap_dot[digit_idx].
  - OFF: all remaining cycles of the slot. Identical to BLANK.
- Lit window: brightness b gives (b+1)*STEP lit cycles per slot. There is no fully-dark level; use ctrl_en for off.
- Latency: every output is a flop. Output at cycle t+1 reflects cnt/digit_idx/en_q at cycle t. Total ctrl_en -> pin latency is 2 cycles.
- Mid-operation events:
  - ctrl_en falling mid-slot: outputs inactive 2 cycles later; the partial frame is abandoned.
  - ctrl_en re-rising: the next frame starts fresh at digit 0 with BLANK.
  - Input changes mid-frame: ignored until the next digit-0 slot start.
  - Async reset mid-slot: outputs go inactive immediately, with no clock edge required.
  - Reset release: scanning begins only after en_q=1.
- Never more than one select active in any cycle, including across wrap and disable.
- Width rules:
  - cnt width = $clog2(DIGIT_PERIOD).
  - Step computation uses a separate step counter (reset at BLANK end, wraps at STEP-1) plus a 4-bit step index, rather than a divider.

Decomposition:
- Shared package sev_seg_pkg:
  - segment bit-index constants (SEG_A..SEG_G);
  - NUM_DIGITS=4;
  - phase encoding (PH_BLANK, PH_ON, PH_OFF) as 2-bit localparams.
- One sub-module is natural: sev_seg_slot_timer. It owns cnt, the step counter, the step index and digit_idx. It outputs the phase, digit_idx and a frame_start pulse.
- The top level holds en_q, the snapshot and the output polarity/registering.

Test Plan:
All scenarios use DIGIT_PERIOD=40, BLANK_CYCLES=8 (STEP=2), both polarities active-low.
1. Reset: hold rst=0 with random inputs -> sel_out=4'hF, seg_out=7'h7F, dp_out=1. Release with ctrl_en=0 for 100 cycles -> unchanged.
2. Basic scan:
   - Stimulus: digits 7'h3F, 7'h06, 7'h5B, 7'h4F; dots 4'b0101; brightness F; ctrl_en=1.
   - Frame slots: sel_out=4'hE for 32 cycles with seg_out=7'h40, dp_out=0; then 8 blank cycles (sel 4'hF); then 4'hD with seg 7'h79, dp 1; then 4'hB with seg 7'h24, dp 0; then 4'h7 with seg 7'h30, dp 1.
   - Each lit window is preceded by exactly 8 blank cycles. Frame length = 160 cycles.
3. Brightness 3 -> per slot, 8 cycles lit then 24 dark. Brightness 0 -> 2 cycles lit. Checker asserts at most one sel bit low at any time.
4. No tearing: change ctrl_digit_2 to 7'h7F while digit 1 is lit -> digit 2 still shows 7'h24 in this frame and shows 7'h00 (pins) from the next frame.
5. Disable/re-enable: drop ctrl_en in the digit-2 ON phase -> pins inactive 2 cycles later. Re-raise -> 8 blank cycles, then digit 0 (sel 4'hE).
6. Async reset mid-ON: pull rst low between clock edges -> pins inactive before the next edge. Counters and snapshot restart on release.
